// File: rtl/bot_sysreg_capture.sv
// bot_sysreg_capture: snapshots the Rojobot system registers on each rising
// edge of upd_sysregs into a small show-ahead FIFO for the application CPU.
// Optional build macro BOTCAP_TIMESTAMP_EN adds a 16-bit cycle timestamp to
// every stored entry, presented on snap_tstamp.
module bot_sysreg_capture #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          upd_sysregs,
    input  logic [7:0]    LocX_in,
    input  logic [7:0]    LocY_in,
    input  logic [7:0]    Sensors_in,
    input  logic [7:0]    BotInfo_in,
    input  logic          rd_pop,
    input  logic          clr_ovf,
    output logic          snap_valid,
    output logic [7:0]    snap_LocX,
    output logic [7:0]    snap_LocY,
    output logic [7:0]    snap_Sensors,
    output logic [7:0]    snap_BotInfo,
    output logic          irq,
    output logic [AW:0]   fill_cnt,
    output logic [7:0]    ovf_cnt
`ifdef BOTCAP_TIMESTAMP_EN
    ,
    output logic [15:0]   snap_tstamp
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic          upd_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill_next;
    logic          push;
    logic          pop_ok;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   head;

    assign push   = upd_sysregs & ~upd_q;
    assign pop_ok = rd_pop & snap_valid;
    assign full   = (fill_cnt == FULL_CNT);
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign wr_en  = push & (~full | pop_ok);
    assign drop   = push & full & ~pop_ok;

    // Edge-detect register for the update flag.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) upd_q <= 1'b0;
        else        upd_q <= upd_sysregs;
    end

    // Next occupancy from the explicit push/pop pair.
    // NOTE: default assigned first so no path leaves fill_next unassigned (no latch).
    always_comb begin
        fill_next = fill_cnt;
        case ({wr_en, pop_ok})
            2'b10:   fill_next = fill_cnt + (AW + 1)'(1);
            2'b01:   fill_next = fill_cnt - (AW + 1)'(1);
            default: fill_next = fill_cnt;
        endcase
    end

    // Pointers, occupancy and the registered valid/interrupt flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_cnt   <= '0;
            snap_valid <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            fill_cnt   <= fill_next;
            snap_valid <= (fill_next != '0);
            irq        <= (fill_next != '0);
        end
    end

    // Snapshot storage, packed {BotInfo, Sensors, LocY, LocX}.
    // NOTE: storage is not reset; empty entries are masked by snap_valid instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {BotInfo_in, Sensors_in, LocY_in, LocX_in};
    end

    // Saturating drop counter; a clear coinciding with a drop leaves one count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      ovf_cnt <= 8'd0;
        else if (clr_ovf)                ovf_cnt <= drop ? 8'd1 : 8'd0;
        else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end

    // Show-ahead head outputs, forced to zero while empty.
    assign head         = snap_valid ? mem[rd_ptr] : 32'd0;
    assign snap_LocX    = head[7:0];
    assign snap_LocY    = head[15:8];
    assign snap_Sensors = head[23:16];
    assign snap_BotInfo = head[31:24];

`ifdef BOTCAP_TIMESTAMP_EN
    logic [15:0] tstamp;
    logic [15:0] ts_mem [DEPTH];

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tstamp <= 16'd0;
        else        tstamp <= tstamp + 16'd1;
    end

    // Timestamp stored alongside each accepted snapshot.
    always_ff @(posedge clk) begin
        if (wr_en) ts_mem[wr_ptr] <= tstamp;
    end

    assign snap_tstamp = snap_valid ? ts_mem[rd_ptr] : 16'd0;
`endif

endmodule

// File: doc/bot_sysreg_capture.md
Name: bot_sysreg_capture

Overview:
- Downstream consumer of the Rojobot simulator's system registers: LocX, Loc_Y, Sensors, BotInfo and the upd_sysregs update flag.
- On every rising edge of upd_sysregs it takes a coherent 32-bit snapshot of the four registers and pushes it into a small show-ahead FIFO.
- The Application CPU pops snapshots at its own pace, so no update is torn or silently lost. A level interrupt and a saturating overflow counter report backlog and drops.

Parameters:
- DEPTH, 4, number of snapshot entries; power of two, minimum 2.
- AW, 2, pointer width; log2(DEPTH).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- upd_sysregs  input  1  update flag from the bot; a snapshot is taken on its rising edge
- LocX_in  input  8  X-coordinate register
- LocY_in  input  8  Y-coordinate register
- Sensors_in  input  8  sensor register
- BotInfo_in  input  8  bot info register
- rd_pop  input  1  consumer pop request; one entry per asserted cycle
- clr_ovf  input  1  synchronous clear of ovf_cnt
- snap_valid  output  1  FIFO not empty; head entry is valid
- snap_LocX  output  8  head entry LocX
- snap_LocY  output  8  head entry LocY
- snap_Sensors  output  8  head entry Sensors
- snap_BotInfo  output  8  head entry BotInfo
- irq  output  1  level interrupt; equals snap_valid
- fill_cnt  output  AW+1  number of entries held, 0..DEPTH
- ovf_cnt  output  8  count of dropped snapshots, saturating

Behaviour:
- Clock, reset and sampling
  - Single clock domain.
  - Reset is asynchronous and active-low. While reset is low: pointers = 0, fill_cnt = 0, snap_valid = 0, irq = 0, ovf_cnt = 0, edge-detect register upd_q = 0.
  - Snapshot data outputs read 0 while empty.
  - Reset mid-operation discards all entries immediately.
- Push
  - push = upd_sysregs & ~upd_q; upd_q is registered every cycle.
  - A level held high produces exactly one push. A new push needs a 0 then a 1.
  - The first high cycle after reset release counts as a rising edge.
  - Data captured is the *_in values present in the edge-detect cycle N, packed {BotInfo, Sensors, LocY, LocX}.
  - Entry is written at the end of cycle N. snap_valid and fill_cnt reflect it in cycle N+1.
- Pop
  - pop_ok = rd_pop & snap_valid. The head outputs come straight from the head entry (show-ahead).
  - After pop_ok in cycle M, the next entry (or empty) is visible in cycle M+1.
  - rd_pop while empty is ignored, with no pointer or count change.
- Boundary cases
  - Push and pop_ok in the same cycle: both occur, fill_cnt unchanged. This holds when full too, with no drop.
  - Full with push and no pop_ok: the snapshot is dropped, the oldest data is kept, and ovf_cnt increments.
  - ovf_cnt saturates at 255.
  - clr_ovf alone sets ovf_cnt to 0. clr_ovf coinciding with a drop sets ovf_cnt to 1.
- Pointers and counts
  - Pointers wrap modulo DEPTH.
  - fill_cnt is tracked explicitly, never derived from pointer difference alone.
  - irq = snap_valid, registered; there is no separate acknowledge, so popping to empty clears irq.

Optional Feature:
- Macro name: BOTCAP_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter runs from reset = 0 and wraps at 65535.
  - Its cycle-N value is stored with each pushed entry.
  - Added output snap_tstamp (16) presents the head entry's timestamp; it reads 0 when empty.
  - Dropped snapshots do not store a timestamp.
- Undefined: no counter, no extra storage, port absent. All other behaviour is identical.

Test Plan:
- Reset release, all *_in = 0x00, no upd → snap_valid = 0, irq = 0, fill_cnt = 0, ovf_cnt = 0, snap_LocX = 0.
- LocX/LocY/Sensors/BotInfo = 0x12/0x34/0x56/0x78, upd_sysregs high 1 cycle in cycle N → cycle N+1 snap_valid = 1, irq = 1, snap_LocX = 0x12, snap_BotInfo = 0x78, fill_cnt = 1. rd_pop 1 cycle → snap_valid = 0 next cycle.
- upd_sysregs held high 10 cycles → exactly one entry, fill_cnt = 1.
- 6 upd pulses with LocX = 1..6, no pops (DEPTH = 4) → fill_cnt = 4, ovf_cnt = 2. Pops return LocX 1, 2, 3, 4, then empty. clr_ovf → ovf_cnt = 0.
- Full FIFO, push and rd_pop in the same cycle → fill_cnt stays 4, ovf_cnt unchanged, new head = 2nd oldest, newest entry at tail.
- rd_pop with FIFO empty, and reset asserted while fill_cnt = 3 → no change on the first; all outputs 0 immediately on the second. With BOTCAP_TIMESTAMP_EN, pushes 5 cycles apart show snap_tstamp differing by 5.
